elastic_pipe: RTL

ELASTIC_PIPE -- requirements
Module: elastic_pipe

---
 rtl/elastic_pipe_if.sv | 29 ++
 rtl/elastic_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_if.sv
// Handshake bundle for elastic_pipe: upstream valid/ready/data, downstream
// valid/ready/data, flush and the occupancy count.
// The slave modport is the pipe's view; the master modport is the view of
// whatever drives the pipe and consumes its output.
interface elastic_pipe_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(2 * DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH-stage valid/ready register pipeline with flush and an
// occupancy counter.
// Optional feature macro: ELASTIC_PIPE_SKID_EN
//   undefined : one register per stage, in_ready is combinational from
//               out_ready, capacity DEPTH.
//   defined   : each stage gets a skid register, in_ready comes straight
//               from a flop, capacity 2*DEPTH.
// Latency through an empty pipe is DEPTH cycles in both builds.
module elastic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    elastic_pipe_if.slave bus
);
    localparam int CW = $clog2(2 * DEPTH + 1);
`ifdef ELASTIC_PIPE_SKID_EN
    localparam int CAP = 2 * DEPTH;
`else
    localparam int CAP = DEPTH;
`endif
    localparam logic [CW-1:0] CAP_CNT = CW'(CAP);

    // Head register of each stage; the last one drives out_valid/out_data.
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];

    // What each stage is offered by its upstream neighbour this cycle.
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] up_data [DEPTH];

    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    assign bus.out_valid = stage_valid[DEPTH-1] && !bus.flush;
    assign bus.out_data  = stage_data[DEPTH-1];
    assign bus.count     = count_q;

    // Stage 0 is fed by the accepted input, every other stage by its predecessor's head.
    always_comb begin
        up_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            up_data[k] = '0;
        end
        up_valid[0] = in_xfer;
        up_data[0]  = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_valid[k] = stage_valid[k-1];
            up_data[k]  = stage_data[k-1];
        end
    end

`ifdef ELASTIC_PIPE_SKID_EN
    logic [DEPTH-1:0] skid_valid;
    logic [WIDTH-1:0] skid_data [DEPTH];
    logic [DEPTH-1:0] down_ready;
    logic [DEPTH-1:0] up_xfer;

    // A stage accepts whenever its skid slot is free, so in_ready is just a flop.
    assign bus.in_ready = !skid_valid[0] && !bus.flush && !rst;

    // Downstream readiness of each stage is the (registered) free-skid flag of the next one.
    always_comb begin
        down_ready = '0;
        up_xfer    = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            down_ready[k] = !skid_valid[k+1];
        end
        down_ready[DEPTH-1] = bus.out_ready;
        for (int k = 0; k < DEPTH; k++) begin
            up_xfer[k] = up_valid[k] && !skid_valid[k];
        end
    end

    // Head refills from the skid first; a stalled head diverts the incoming entry into the skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
            skid_valid  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
                skid_data[k]  <= '0;
            end
        end else if (bus.flush) begin
            stage_valid <= '0;
            skid_valid  <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!stage_valid[k] || down_ready[k]) begin
                    if (skid_valid[k]) begin
                        stage_valid[k] <= 1'b1;
                        stage_data[k]  <= skid_data[k];
                        skid_valid[k]  <= 1'b0;
                    end else begin
                        stage_valid[k] <= up_xfer[k];
                        if (up_xfer[k]) begin
                            stage_data[k] <= up_data[k];
                        end
                    end
                end else if (up_xfer[k]) begin
                    skid_valid[k] <= 1'b1;
                    skid_data[k]  <= up_data[k];
                end
            end
        end
    end
`else
    // stage_ready[k]: stage k may load this cycle; index DEPTH is the sink.
    logic [DEPTH:0] stage_ready;

    assign bus.in_ready = stage_ready[0] && !bus.flush && !rst;

    // Ready ripples back from the sink: a stage may load when empty or when its entry moves on.
    always_comb begin
        stage_ready        = '0;
        stage_ready[DEPTH] = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            stage_ready[k] = !stage_valid[k] || stage_ready[k+1];
        end
    end

    // Every stage that may load takes whatever its upstream offers, bubble or entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
            end
        end else if (bus.flush) begin
            stage_valid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (stage_ready[k]) begin
                    stage_valid[k] <= up_valid[k];
                    if (up_valid[k]) begin
                        stage_data[k] <= up_data[k];
                    end
                end
            end
        end
    end
`endif

    // Occupancy follows the two handshakes; flush empties it, and it never passes capacity or zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.flush) begin
            count_q <= '0;
        end else if (in_xfer && !out_xfer && count_q != CAP_CNT) begin
            count_q <= count_q + 1'b1;
        end else if (out_xfer && !in_xfer && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end
endmodule
